// File: rtl/apb_pin_ctrl_pkg.sv
// Shared constants for the APB pin controller: register word offsets and reset defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package apb_pin_ctrl_pkg;

    // Word offsets decoded from PADDR[4:2]
    localparam logic [2:0] OFF_LEVEL   = 3'd0;
    localparam logic [2:0] OFF_SET     = 3'd1;
    localparam logic [2:0] OFF_CLR     = 3'd2;
    localparam logic [2:0] OFF_PWIDTH  = 3'd3;
    localparam logic [2:0] OFF_PULSE   = 3'd4;
    localparam logic [2:0] OFF_DONE    = 3'd5;
    localparam logic [2:0] OFF_IRQ_EN  = 3'd6;
    localparam logic [2:0] OFF_INVALID = 3'd7;

    // Pulse width after reset, in PCLK cycles
    localparam int unsigned PWIDTH_RST = 1;

endpackage

// File: rtl/apb_pin_ctrl_if.sv
// APB3 bus bundle between the MSS master (via CoreAPB3) and the pin controller slave.
// Latency: wires only; the slave answers with zero wait states.
// Backpressure: none, PREADY is tied high by the slave.
// Signals: PSEL/PENABLE/PWRITE control, PADDR/PWDATA request, PRDATA/PREADY/PSLVERR response.
interface apb_pin_ctrl_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pin_ctrl_pulse_timer.sv
// One-shot pulse timer for a single pin: IDLE/RUN down-counter with a one-cycle done strobe.
// Latency: active rises the edge after start; done_pulse is high in the cycle before the edge that ends RUN.
// Backpressure: none; a start during RUN reloads the counter and suppresses done for the cut pulse.
// Ports: clk/rst_n, start (one-cycle), width[CNT_W]; outputs active, done_pulse.
module pin_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] width,
    output logic             active,
    output logic             done_pulse
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zdone_q, zdone_d;
    logic             expire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zdone_d = 1'b0;
        expire  = 1'b0;
        if (start) begin
            if (width == '0) begin
                // Zero width: no pulse, but report completion one edge later
                state_d = ST_IDLE;
                cnt_d   = '0;
                zdone_d = 1'b1;
            end else begin
                // Start or retrigger: reload, stay/enter RUN, no done for a cut pulse
                state_d = ST_RUN;
                cnt_d   = width;
            end
        end else if (state_q == ST_RUN) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                expire  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zdone_q <= zdone_d;
        end
    end

    assign active     = (state_q == ST_RUN);
    assign done_pulse = expire | zdone_q;

endmodule

// File: rtl/apb_pin_ctrl.sv
// APB3 slave driving NUM_PINS fabric pins: level/set/clear registers, per-pin one-shot pulses, done IRQ.
// Latency: zero-wait-state APB; PIN_OUT and IRQ are one register stage behind the control state.
// Backpressure: none, PREADY is constant 1; offset 7 answers with PSLVERR.
// Ports: PCLK/PRESERN, apb (slave modport), PIN_OUT[NUM_PINS], IRQ.
module apb_pin_ctrl
    import apb_pin_ctrl_pkg::*;
#(
    parameter int                  NUM_PINS  = 4,
    parameter int                  CNT_W     = 16,
    parameter logic [NUM_PINS-1:0] RESET_VAL = '0
) (
    input  logic                PCLK,
    input  logic                PRESERN,
    apb_pin_ctrl_if.slave       apb,
    output logic [NUM_PINS-1:0] PIN_OUT,
    output logic                IRQ
);

    logic [2:0]          off;
    logic                wr_en;
    logic                rd_en;
    logic [NUM_PINS-1:0] wdat_pins;

    logic [NUM_PINS-1:0] level_q, level_d;
    logic [CNT_W-1:0]    pwidth_q, pwidth_d;
    logic [NUM_PINS-1:0] done_q, done_d;
    logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PINS-1:0] pin_q;
    logic                irq_q;

    logic [NUM_PINS-1:0] start;
    logic [NUM_PINS-1:0] active;
    logic [NUM_PINS-1:0] done_pulse;
    logic [31:0]         rdata;

    assign off       = apb.PADDR[4:2];
    assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_en     = apb.PSEL & ~apb.PWRITE;
    assign wdat_pins = apb.PWDATA[NUM_PINS-1:0];

    assign start = (wr_en && off == OFF_PULSE) ? wdat_pins : '0;

    always_comb begin
        level_d  = level_q;
        pwidth_d = pwidth_q;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            case (off)
                OFF_LEVEL:  level_d  = wdat_pins;
                OFF_SET:    level_d  = level_q | wdat_pins;
                OFF_CLR:    level_d  = level_q & ~wdat_pins;
                OFF_PWIDTH: pwidth_d = apb.PWDATA[CNT_W-1:0];
                OFF_IRQ_EN: irq_en_d = wdat_pins;
                default:    ;
            endcase
        end
        // Clear first, then OR in new completions so a same-cycle set beats W1C
        done_d = done_q;
        if (wr_en && off == OFF_DONE) begin
            done_d = done_q & ~wdat_pins;
        end
        done_d = done_d | done_pulse;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            level_q  <= RESET_VAL;
            pwidth_q <= CNT_W'(PWIDTH_RST);
            done_q   <= '0;
            irq_en_q <= '0;
            pin_q    <= RESET_VAL;
            irq_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            pwidth_q <= pwidth_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            // A running pulse drives the inverse of the current static level
            pin_q    <= level_q ^ active;
            irq_q    <= |(done_q & irq_en_q);
        end
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_timer
        pin_pulse_timer #(
            .CNT_W (CNT_W)
        ) u_timer (
            .clk        (PCLK),
            .rst_n      (PRESERN),
            .start      (start[i]),
            .width      (pwidth_q),
            .active     (active[i]),
            .done_pulse (done_pulse[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (off)
                OFF_LEVEL:  rdata = 32'(level_q);
                OFF_PWIDTH: rdata = 32'(pwidth_q);
                OFF_PULSE:  rdata = 32'(active);
                OFF_DONE:   rdata = 32'(done_q);
                OFF_IRQ_EN: rdata = 32'(irq_en_q);
                default:    rdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & (off == OFF_INVALID);

    assign PIN_OUT = pin_q;
    assign IRQ     = irq_q;

    // Address bits outside [4:2] are not decoded
    logic unused_bits;
    assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA};

endmodule

// File: doc/apb_pin_ctrl.md
# apb_pin_ctrl

APB3 slave that drives a bank of `NUM_PINS` fabric output pins (LCD command/data select, chip enables, resets) from the MSS master APB via CoreAPB3. It generalises the single-pin `CD` controller. Each pin has:
- a static level register with set/clear aliases;
- a programmable one-shot pulse, timed by a per-pin down-counter;
- a sticky pulse-done flag feeding a maskable interrupt.

## Interface
Parameters:
- `NUM_PINS`, 4, number of controlled pins (1..16).
- `CNT_W`, 16, pulse-width counter width (2..32).
- `RESET_VAL`, 0, `NUM_PINS`-bit pin level after reset.

Ports:
- `PCLK`  in  1  fabric clock (MSS `FAB_CLK`).
- `PRESERN`  in  1  reset, asynchronous, active-low (MSS `M2F_RESET_N`).
- `PSEL`, `PENABLE`, `PWRITE`  in  1  APB3 control.
- `PADDR`  in  32  byte address; only [4:2] decoded.
- `PWDATA`  in  32  write data.
- `PRDATA`  out  32  read data.
- `PREADY`  out  1  constant 1.
- `PSLVERR`  out  1  error on invalid offset.
- `PIN_OUT`  out  `NUM_PINS`  registered pin outputs.
- `IRQ`  out  1  registered, active-high interrupt.

## Operation
Register map (word offset = `PADDR[4:2]`). Bits above `NUM_PINS`/`CNT_W` read 0 and ignore writes.
- 0 `LEVEL` (RW): static level per pin.
- 1 `SET` (W): write-1 sets `LEVEL` bits. Reads 0.
- 2 `CLR` (W): write-1 clears `LEVEL` bits. Reads 0.
- 3 `PWIDTH` (RW): pulse width in `PCLK` cycles, [`CNT_W`-1:0].
- 4 `PULSE` (W): write-1 starts a pulse on that pin. Reads the per-pin `active` mask.
- 5 `DONE` (R/W1C): sticky pulse-complete flags.
- 6 `IRQ_EN` (RW): per-pin interrupt enable.
- 7: invalid. Access asserts `PSLVERR`; writes are ignored and reads return 0.

Pin and interrupt outputs:
- `PIN_OUT[i]` is the register of `LEVEL[i] ^ active[i]`, so a pulse is the inverse of the static level.
- `IRQ` is the register of `|(DONE & IRQ_EN)`.

Per-pin pulse timer. States are IDLE (`active`=0) and RUN (`active`=1, `cnt` > 0).
- IDLE → RUN on a `PULSE` write with bit i = 1 and `PWIDTH` ≠ 0. Loads `cnt` = `PWIDTH`.
- RUN: `cnt` decrements each cycle. When `cnt` = 1, the next edge goes to IDLE and sets `DONE[i]`.
- Retrigger in RUN: `cnt` reloads to `PWIDTH`, `active` stays 1, and no `DONE` is set for the cut pulse.
- `PULSE` write with `PWIDTH` = 0: no pulse, and `DONE[i]` is set at the next edge.
- A `PWIDTH` write during RUN affects only later starts.
- Writing `LEVEL`/`SET`/`CLR` during RUN updates `LEVEL` immediately. The output remains inverted relative to the new level.
- A `SET` and a `CLR` bit for the same pin are never simultaneous, since each is a separate write.

Boundary rules:
- `DONE` set event and W1C of the same bit in the same cycle: set wins.
- Reset mid-pulse: the pulse is aborted and no `DONE` is set.

## Timing
- Zero wait states. A write commits on the `PCLK` edge where `PSEL & PENABLE & PWRITE`.
- `PRDATA` is combinational from registers while `PSEL & !PWRITE`, else 0.
- `PSLVERR` is asserted only when `PSEL & PENABLE` with offset 7.
- Level write at edge T: `PIN_OUT` changes after edge T+1 (one register stage).
- `PULSE` write at edge T: `active` = 1 after T. `PIN_OUT` is inverted from T+1 for exactly `PWIDTH` cycles. `DONE` is set at edge T+`PWIDTH`. `IRQ` is asserted after T+`PWIDTH`+1.
- Reset values:
  - `LEVEL` = `RESET_VAL`, `PWIDTH` = 1.
  - `DONE`, `IRQ_EN`, `active`, `cnt` = 0.
  - `PIN_OUT` = `RESET_VAL`, `IRQ` = 0, `PSLVERR` = 0, `PREADY` = 1.

## Structure
- Package `apb_pin_ctrl_pkg`: register offset constants `OFF_LEVEL` … `OFF_IRQ_EN`, `OFF_INVALID`, and the default `PWIDTH` reset value.
- Sub-module `pin_pulse_timer` (instantiated `NUM_PINS` times):
  - inputs: `start`, `width`[`CNT_W`];
  - outputs: `active`, `done_pulse` (one cycle).
- The top holds the APB decode, `LEVEL`/`PWIDTH`/`DONE`/`IRQ_EN` registers and the output registers.

## Test plan
- Reset with `RESET_VAL`=4'b1010 → `PIN_OUT`=1010, `IRQ`=0, read `PWIDTH`=1, read `DONE`=0.
- Write `SET`=0x1, then `CLR`=0x8 → `LEVEL` reads 0x3, `PIN_OUT`=0011 one cycle after each write.
- `PWIDTH`=5, `LEVEL`=0, `PULSE`=0x2 → `PIN_OUT[1]` high for exactly 5 cycles. `DONE`=0x2. `IRQ` stays 0 until `IRQ_EN`=0x2, then rises. W1C `DONE` → `IRQ` falls next cycle.
- `PWIDTH`=10, pulse pin 0, retrigger after 4 cycles → pin high for 14 cycles total, `DONE[0]` set once.
- `PWIDTH`=0, `PULSE`=0x1 → no `PIN_OUT` change, `DONE[0]`=1 next cycle. `PRESERN` low mid-pulse (width 8) → pin returns to `RESET_VAL` immediately, `DONE`=0.
- Read/write offset 0x1C → `PSLVERR`=1 in the access phase, `PRDATA`=0, no register changes. Access to offset 0x10 → `PSLVERR`=0.
